// File: rtl/neuron_bwd.sv
// Backward pass of a 9-input tanh neuron: back-propagated deltas, weight and
// bias update, all through one time-shared saturating fixed-point multiplier.
module neuron_bwd #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [9*WIDTH-1:0] a_flat,
  input  logic [9*WIDTH-1:0] w_flat,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   y,
  input  logic [WIDTH-1:0]   delta_in,
  input  logic [WIDTH-1:0]   lr,
  output logic [9*WIDTH-1:0] da_flat,
  output logic [9*WIDTH-1:0] w_new_flat,
  output logic [WIDTH-1:0]   b_new,
  output logic               busy,
  output logic               done
);

  localparam int N = 9;
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  typedef enum logic [2:0] {
    st_idle, st_yy, st_dz, st_g, st_da, st_wu, st_done
  } state_t;

  state_t state, state_nx;
  logic [3:0] idx;

  // Operands captured on start; the computation never looks at live inputs.
  logic signed [WIDTH-1:0] a_r [N];
  logic signed [WIDTH-1:0] w_r [N];
  logic signed [WIDTH-1:0] b_r, y_r, delta_r, lr_r;

  logic signed [WIDTH-1:0] yy_r, dz_r, g_r, b_new_r;
  logic signed [WIDTH-1:0] da_r [N];
  logic signed [WIDTH-1:0] wn_r [N];

  // x - y evaluated one bit wider, then clamped back to WIDTH.
  function automatic logic signed [WIDTH-1:0] sat_sub(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] yv
  );
    logic signed [WIDTH:0] d;
    d = {x[WIDTH-1], x} - {yv[WIDTH-1], yv};
    if (d[WIDTH] != d[WIDTH-1]) sat_sub = d[WIDTH] ? SMIN : SMAX;
    else                        sat_sub = d[WIDTH-1:0];
  endfunction

  // Shared multiplier: operand selection depends only on the current state.
  logic signed [WIDTH-1:0]   mul_x, mul_y, mul_out;
  logic signed [2*WIDTH-1:0] prod, prod_sh;
  logic [WIDTH:0]            prod_hi;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    unique case (state)
      st_yy: begin mul_x = y_r;     mul_y = y_r;               end
      st_dz: begin mul_x = delta_r; mul_y = sat_sub(ONE, yy_r); end
      st_g:  begin mul_x = lr_r;    mul_y = dz_r;              end
      st_da: begin mul_x = dz_r;    mul_y = w_r[idx];          end
      st_wu: begin mul_x = g_r;     mul_y = a_r[idx];          end
      default: ;
    endcase
  end

  assign prod    = $signed({{WIDTH{mul_x[WIDTH-1]}}, mul_x}) *
                   $signed({{WIDTH{mul_y[WIDTH-1]}}, mul_y});
  assign prod_sh = prod >>> FRAC;
  assign prod_hi = prod_sh[2*WIDTH-1:WIDTH-1];
  assign mul_out = ((&prod_hi) || !(|prod_hi)) ? prod_sh[WIDTH-1:0]
                 : (prod_sh[2*WIDTH-1] ? SMIN : SMAX);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= st_idle;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      st_idle: if (start) state_nx = st_yy;
      st_yy:   state_nx = st_dz;
      st_dz:   state_nx = st_g;
      st_g:    state_nx = st_da;
      st_da:   state_nx = st_wu;
      st_wu:   state_nx = (idx == 4'd8) ? st_done : st_da;
      st_done: state_nx = st_idle;
      default: state_nx = st_idle;
    endcase
  end

  // NOTE: operand capture registers carry no reset; they are always loaded on start before anything reads them.
  always_ff @(posedge clk) begin
    if (state == st_idle && start) begin
      for (int i = 0; i < N; i++) begin
        a_r[i] <= a_flat[i*WIDTH +: WIDTH];
        w_r[i] <= w_flat[i*WIDTH +: WIDTH];
      end
      b_r     <= b;
      y_r     <= y;
      delta_r <= delta_in;
      lr_r    <= lr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      yy_r    <= '0;
      dz_r    <= '0;
      g_r     <= '0;
      b_new_r <= '0;
      for (int i = 0; i < N; i++) begin
        da_r[i] <= '0;
        wn_r[i] <= '0;
      end
    end else begin
      unique case (state)
        st_idle: if (start) idx <= '0;
        st_yy:   yy_r <= mul_out;
        st_dz:   dz_r <= mul_out;
        st_g:    g_r  <= mul_out;
        st_da:   da_r[idx] <= mul_out;
        st_wu: begin
          wn_r[idx] <= sat_sub(w_r[idx], mul_out);
          if (idx == 4'd8) b_new_r <= sat_sub(b_r, g_r);
          else             idx     <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign da_flat[i*WIDTH +: WIDTH]    = da_r[i];
    assign w_new_flat[i*WIDTH +: WIDTH] = wn_r[i];
  end

  assign b_new = b_new_r;
  assign busy  = (state != st_idle);
  assign done  = (state == st_done);

endmodule

// File: tb/tb_neuron_bwd.sv
// Directed bench for neuron_bwd (WIDTH=32, FRAC=16) with hand-computed results.
module tb_neuron_bwd;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [9*W-1:0] a_flat = '0, w_flat = '0;
  logic [W-1:0]   b = '0, y = '0, delta_in = '0, lr = '0;
  logic [9*W-1:0] da_flat, w_new_flat;
  logic [W-1:0]   b_new;
  logic           busy, done;

  neuron_bwd #(.WIDTH(32), .FRAC(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_flat(a_flat), .w_flat(w_flat), .b(b), .y(y),
    .delta_in(delta_in), .lr(lr),
    .da_flat(da_flat), .w_new_flat(w_new_flat), .b_new(b_new),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_da [9];
  logic [31:0] exp_wn [9];
  logic [31:0] exp_bn;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_all(input logic [31:0] yv, dv, lv, bv, av, wv);
    y = yv; delta_in = dv; lr = lv; b = bv;
    for (int i = 0; i < 9; i++) begin
      a_flat[i*32 +: 32] = av;
      w_flat[i*32 +: 32] = wv;
    end
  endtask

  task automatic expect_all(input logic [31:0] dv, wv, bv);
    for (int i = 0; i < 9; i++) begin
      exp_da[i] = dv;
      exp_wn[i] = wv;
    end
    exp_bn = bv;
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s da%0d", tag, i + 1), {32'd0, da_flat[i*32 +: 32]}, {32'd0, exp_da[i]});
      check($sformatf("%s wn%0d", tag, i + 1), {32'd0, w_new_flat[i*32 +: 32]}, {32'd0, exp_wn[i]});
    end
    check({tag, " b_new"}, {32'd0, b_new}, {32'd0, exp_bn});
  endtask

  // Leaves the caller just after edge k, with start already dropped.
  task automatic start_op();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    do begin
      @(posedge clk) #1;
      n++;
    end while (!done && n < 60);
  endtask

  task automatic do_op(input string tag);
    int n;
    start_op();
    check({tag, " busy"}, {63'd0, busy}, 64'd1);
    n = 0;
    wait_done(n);
    check({tag, " latency"}, n, 21);
    check_results(tag);
    @(posedge clk) #1;
    check({tag, " done_off"}, {63'd0, done}, 64'd0);
    check({tag, " idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic count_dones(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk) #1;
      if (done) seen++;
    end
  endtask

  initial begin
    int n, seen;

    // reset state
    #2 rst = 1'b1;
    #1;
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    expect_all(32'd0, 32'd0, 32'd0);
    check_results("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // basic gradient: dz=1, g=1
    load_all(32'd0, 32'd65536, 32'd65536, 32'd0, 32'd65536, 32'd131072);
    expect_all(32'd131072, 32'd65536, 32'hFFFF0000);
    do_op("r033");

    // y=1 => tanh derivative zero
    load_all(32'd65536, 32'd65536, 32'd65536, 32'd0, 32'd65536, 32'd131072);
    expect_all(32'd0, 32'd131072, 32'd0);
    do_op("r034");

    // fractional values on element 1 only
    load_all(32'd32768, 32'd65536, 32'd32768, 32'd0, 32'd0, 32'd0);
    a_flat[31:0] = 32'd65536;
    w_flat[31:0] = 32'd65536;
    expect_all(32'd0, 32'd0, 32'hFFFFA000);
    exp_da[0] = 32'd49152;
    exp_wn[0] = 32'd40960;
    do_op("r035");

    // positive multiplier saturation
    load_all(32'd0, 32'd262144, 32'd0, 32'd0, 32'd0, 32'd0);
    w_flat[31:0] = 32'h7FFF0000;
    expect_all(32'd0, 32'd0, 32'd0);
    exp_da[0] = 32'h7FFFFFFF;
    exp_wn[0] = 32'h7FFF0000;
    do_op("r036");

    // negative saturation of product and of subtraction; signed operands
    load_all(32'd0, 32'd65536, 32'd65536, 32'h80000000, 32'd0, 32'd0);
    a_flat[31:0]  = 32'd65536;      w_flat[31:0]  = 32'h80000000;
    a_flat[63:32] = 32'hFFFF0000;   w_flat[63:32] = 32'd65536;
    a_flat[95:64] = 32'd0;          w_flat[95:64] = 32'hFFFFFFFF;
    expect_all(32'd0, 32'd0, 32'h80000000);
    exp_da[0] = 32'h80000000;  exp_wn[0] = 32'h80000000;
    exp_da[1] = 32'd65536;     exp_wn[1] = 32'd131072;
    exp_da[2] = 32'hFFFFFFFF;  exp_wn[2] = 32'hFFFFFFFF;
    do_op("negsat");

    // start while busy ignored; inputs changed mid-op; old outputs held
    load_all(32'd0, 32'd65536, 32'd65536, 32'd0, 32'd65536, 32'd131072);
    start_op();
    repeat (2) @(posedge clk);
    #1;
    check("hold da1", {32'd0, da_flat[31:0]}, 64'h80000000);
    start = 1'b1;
    load_all(32'd12345, 32'd777, 32'd999, 32'd5, 32'd42, 32'd4242);
    @(posedge clk) #1 start = 1'b0;
    n = 3;
    wait_done(n);
    check("busy_start latency", n, 21);
    expect_all(32'd131072, 32'd65536, 32'hFFFF0000);
    check_results("busy_start");
    count_dones(30, seen);
    check("busy_start extra_done", seen, 0);

    // reset mid-operation
    load_all(32'd0, 32'd65536, 32'd65536, 32'd0, 32'd65536, 32'd131072);
    start_op();
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    expect_all(32'd0, 32'd0, 32'd0);
    check_results("abort");
    @(negedge clk) rst = 1'b0;
    count_dones(30, seen);
    check("abort no_done", seen, 0);
    expect_all(32'd131072, 32'd65536, 32'hFFFF0000);
    do_op("after_rst");

    // start held high: back-to-back operations 23 cycles apart
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1;
    n = 0;
    wait_done(n);
    check("held1 latency", n, 21);
    check_results("held1");
    load_all(32'd65536, 32'd65536, 32'd65536, 32'd0, 32'd65536, 32'd131072);
    expect_all(32'd0, 32'd131072, 32'd0);
    n = 0;
    wait_done(n);
    check("held2 spacing", n, 23);
    check_results("held2");
    load_all(32'd32768, 32'd65536, 32'd32768, 32'd0, 32'd0, 32'd0);
    a_flat[31:0] = 32'd65536;
    w_flat[31:0] = 32'd65536;
    expect_all(32'd0, 32'd0, 32'hFFFFA000);
    exp_da[0] = 32'd49152;
    exp_wn[0] = 32'd40960;
    n = 0;
    wait_done(n);
    check("held3 spacing", n, 23);
    check_results("held3");
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("held end idle", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_bwd.md
NEURON_BWD -- requirements
Module: neuron_bwd

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width, two's-complement signed fixed point.
REQ-002 SHALL have parameter FRAC, default 16: fraction bits; ONE = 2^FRAC.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request, sampled only in IDLE.
REQ-006 SHALL have port a_flat  input  9*WIDTH  forward activations a_1..a_9; a_1 in bits [WIDTH-1:0].
REQ-007 SHALL have port w_flat  input  9*WIDTH  forward weights w_1..w_9, same packing.
REQ-008 SHALL have port b  input  WIDTH  forward bias.
REQ-009 SHALL have port y  input  WIDTH  forward tanh output of the neuron.
REQ-010 SHALL have port delta_in  input  WIDTH  loss gradient dL/dy.
REQ-011 SHALL have port lr  input  WIDTH  learning rate.
REQ-012 SHALL have port da_flat  output  9*WIDTH  back-propagated deltas da_i, same packing.
REQ-013 SHALL have port w_new_flat  output  9*WIDTH  updated weights, same packing.
REQ-014 SHALL have port b_new  output  WIDTH  updated bias.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse, results valid.

Function
REQ-017 fxmul(x,y) SHALL be the full 2*WIDTH signed product arithmetically shifted right by FRAC, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-018 All subtractions SHALL be computed at WIDTH+1 bits and saturated to WIDTH the same way.
REQ-019 Exactly one fxmul instance SHALL be used, time-shared across states.
REQ-020 States SHALL be IDLE, YY, DZ, G, DA, WU, DONE, with a 4-bit index idx (0..8).
REQ-021 IDLE: on start=1 at edge k, SHALL latch all inputs, clear idx, go to YY; start=0 stays IDLE.
REQ-022 YY: yy = fxmul(y,y) -> DZ; DZ: dz = fxmul(delta_in, sat(ONE - yy)) -> G; G: g = fxmul(lr, dz) -> DA.
REQ-023 DA: da_idx = fxmul(dz, w_idx) -> WU.
REQ-024 WU: w_new_idx = sat(w_idx - fxmul(g, a_idx)); if idx=8 go to DONE and write b_new = sat(b - g), else idx+1 -> DA.
REQ-025 DONE: done=1 for exactly that cycle, then IDLE unconditionally.
REQ-026 Latency: done SHALL be high in the cycle after edge k+21 (start sampled at edge k).
REQ-027 start SHALL be ignored while busy=1; no queuing.
REQ-028 start held high SHALL begin a new operation at the first IDLE edge after DONE (one idle cycle between operations).
REQ-029 Latched inputs SHALL be used throughout; input changes after edge k SHALL NOT affect results.
REQ-030 Outputs SHALL hold their last values until overwritten by the next operation; elements not yet rewritten keep old values mid-operation.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, idx=0, busy=0, done=0, and all of da_flat, w_new_flat, b_new and internal yy/dz/g registers to 0.
REQ-032 Reset asserted mid-operation SHALL abort it with no done pulse; the next start after release SHALL complete normally.

Verification (WIDTH=32, FRAC=16, ONE=65536)
REQ-033 y=0, delta_in=65536, lr=65536, all a_i=65536, all w_i=131072, b=0, start -> after 21 cycles done=1, all da_i=131072, all w_new_i=65536, b_new=-65536.
REQ-034 y=65536, other inputs as REQ-033 -> dz=0, all da_i=0, all w_new_i=131072, b_new=0.
REQ-035 y=32768, delta_in=65536, lr=32768, a_1=65536, w_1=65536, b=0 -> da_1=49152, w_new_1=40960, b_new=-24576.
REQ-036 y=0, delta_in=262144, lr=0, w_1=0x7FFF0000 -> da_1=0x7FFFFFFF (saturated), w_new_1=0x7FFF0000.
REQ-037 start pulse at cycle 3 of a busy operation -> ignored, single done; rst pulse at cycle 10 -> busy=0 and outputs 0 at once, no done; a fresh REQ-033 run then matches REQ-033.
REQ-038 start held high for 3 operations -> done pulses exactly 23 cycles apart (21 for processing, DONE, one IDLE), each with correct results.
